// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CSUM,
    DONE,
    ERR
  } loader_state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int LANE_W         = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/imem_loader_word_packer.sv
// Byte-to-word packer: little-endian lane assembly with zero padding on an early flush.
module imem_word_packer
  import imem_loader_pkg::*;
(
  input  logic                        clk,
  input  logic                        areset,
  input  logic                        en,
  input  logic                        flush,
  input  logic [7:0]                  data,
  output logic                        done,
  output logic [8*BYTES_PER_WORD-1:0] word
);

  logic [LANE_W-1:0]           lane_reg;
  logic [8*BYTES_PER_WORD-1:0] acc_reg;

  // Lanes not yet filled stay zero in acc_reg, which gives the padding for free.
  genvar gi;
  generate
    for (gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
      assign word[8*gi +: 8] = (lane_reg == LANE_W'(gi)) ? data : acc_reg[8*gi +: 8];
    end
  endgenerate

  assign done = en & (flush | (lane_reg == LANE_W'(BYTES_PER_WORD - 1)));

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      lane_reg <= '0;
      acc_reg  <= '0;
    end else if (en) begin
      if (done) begin
        lane_reg <= '0;
        acc_reg  <= '0;
      end else begin
        lane_reg <= lane_reg + 1'b1;
        acc_reg  <= word;
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: streams a byte program into instruction memory and releases the core when done.
// Optional trailing checksum byte is enabled by defining LOADER_CHECKSUM_EN.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              areset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              core_run,
  output logic              busy,
  output logic              error,
  output logic [ADDR_W:0]   word_count
);

  localparam logic [ADDR_W:0] CAPACITY = {1'b1, {ADDR_W{1'b0}}};
`ifdef LOADER_CHECKSUM_EN
  localparam loader_state_t AFTER_LAST = CSUM;
`else
  localparam loader_state_t AFTER_LAST = DONE;
`endif

  if (DATA_W != 32) begin : g_bad_data_w
    $error("imem_loader: DATA_W must be 32");
  end

  loader_state_t     state_reg, state_next;
  logic              we_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [31:0]       wdata_reg;
  logic [ADDR_W:0]   count_reg;
  logic              core_run_reg;
  logic              error_reg;

  logic        accept, loading, overflow, pack_en, word_done;
  logic [31:0] packed_word;

  assign in_ready = (state_reg == IDLE) | (state_reg == LOAD) | (state_reg == CSUM);
  assign accept   = in_valid & in_ready;
  assign loading  = (state_reg == IDLE) | (state_reg == LOAD);
  // word_count already includes a word whose strobe is issuing, so it is the exact fill level.
  assign overflow = accept & loading & (count_reg == CAPACITY);
  assign pack_en  = accept & loading & ~overflow;

  imem_word_packer u_packer (
    .clk    (clk),
    .areset (areset),
    .en     (pack_en),
    .flush  (in_last),
    .data   (in_data),
    .done   (word_done),
    .word   (packed_word)
  );

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] sum_reg;
  logic [7:0] sum_total;
  assign sum_total = sum_reg + in_data;

  always_ff @(posedge clk or posedge areset) begin
    if (areset)       sum_reg <= '0;
    else if (pack_en) sum_reg <= sum_total;
  end
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, LOAD: begin
        if (overflow)    state_next = ERR;
        else if (accept) state_next = in_last ? AFTER_LAST : LOAD;
      end
`ifdef LOADER_CHECKSUM_EN
      CSUM: if (accept) state_next = (sum_total == 8'd0) ? DONE : ERR;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_reg    <= IDLE;
      we_reg       <= 1'b0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      count_reg    <= '0;
      core_run_reg <= 1'b0;
      error_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      we_reg       <= word_done;
      // Registered from the settled state, so the release trails the final strobe.
      core_run_reg <= (state_reg == DONE);
      error_reg    <= error_reg | (state_next == ERR);
      if (word_done) begin
        addr_reg  <= count_reg[ADDR_W-1:0];
        wdata_reg <= packed_word;
        count_reg <= count_reg + 1'b1;
      end
    end
  end

  assign imem_we    = we_reg;
  assign imem_addr  = addr_reg;
  assign imem_wdata = wdata_reg;
  assign core_run   = core_run_reg;
  assign busy       = (state_reg == LOAD) | (state_reg == CSUM);
  assign error      = error_reg;
  assign word_count = count_reg;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader (4-word memory); checksum cases run when LOADER_CHECKSUM_EN is defined.
module tb_imem_loader;

  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          areset = 1'b1;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = '0;
  logic          in_last = 1'b0;
  logic          in_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          core_run;
  logic          busy;
  logic          error;
  logic [AW:0]   word_count;

  imem_loader #(.ADDR_W(AW), .DATA_W(32)) dut (
    .clk        (clk),
    .areset     (areset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_run   (core_run),
    .busy       (busy),
    .error      (error),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  int          writes = 0;
  logic [39:0] exp_q[$];
  logic [7:0]  pbytes[$];
  int          m_lane = 0;
  int          m_addr = 0;
  logic [31:0] m_word = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input int a, input logic [31:0] d);
    exp_q.push_back({8'(a), d});
  endtask

  task automatic model_byte(input logic [7:0] b, input bit l);
    m_word |= 32'(b) << (8 * m_lane);
    if (m_lane == 3 || l) begin
      push_exp(m_addr, m_word);
      m_addr++;
      m_word = '0;
      m_lane = 0;
    end else begin
      m_lane++;
    end
  endtask

  // Write monitor: pops the scoreboard on every strobe.
  always @(negedge clk) begin
    logic [39:0] e;
    if (!areset && imem_we === 1'b1) begin
      writes++;
      $display("write @%0d data 0x%08h core_run=%0b", imem_addr, imem_wdata, core_run);
      check("run_during_we", 32'(core_run), 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_we", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("we_addr", 32'(imem_addr), 32'(e[39:32]));
        check("we_data", imem_wdata, e[31:0]);
      end
    end
  end

  task automatic send(input logic [7:0] b, input bit l);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("ready_timeout", 32'(in_ready), 32'd1);
    end else begin
      in_valid = 1'b1;
      in_data  = b;
      in_last  = l;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
  endtask

  task automatic send_prog(input bit with_last, input bit use_model, input int gapmax);
    bit l;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0] sum;
    sum = '0;
`endif
    for (int i = 0; i < pbytes.size(); i++) begin
      l = with_last && (i == pbytes.size() - 1);
      // Byte 5 always follows byte 4 directly so it lands in the first strobe cycle.
      if (gapmax > 0 && i != 4) repeat ($urandom_range(gapmax, 0)) @(posedge clk);
      if (use_model) model_byte(pbytes[i], l);
`ifdef LOADER_CHECKSUM_EN
      sum = sum + pbytes[i];
`endif
      send(pbytes[i], l);
    end
`ifdef LOADER_CHECKSUM_EN
    if (with_last) send(8'd0 - sum, 1'b0);
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    areset   = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_we", 32'(imem_we), 32'd0);
    check("rst_core_run", 32'(core_run), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_word_count", 32'(word_count), 32'd0);
    @(negedge clk);
    areset = 1'b0;
    writes = 0;
    m_lane = 0;
    m_addr = 0;
    m_word = '0;
  endtask

  task automatic end_prog(input string tag, input int wc);
    repeat (3) @(negedge clk);
    $display("%s: core_run=%0b error=%0b word_count=%0d writes=%0d", tag, core_run, error, word_count, writes);
    check({tag, "_core_run"}, 32'(core_run), 32'd1);
    check({tag, "_error"}, 32'(error), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_word_count"}, 32'(word_count), 32'(wc));
    check({tag, "_writes"}, 32'(writes), 32'(wc));
    check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    pbytes = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    push_exp(0, 32'h0000_0013);
    push_exp(1, 32'h0010_0093);
    send_prog(1'b1, 1'b0, 0);
    end_prog("eight_bytes", 2);

    do_reset();
    pbytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAB};
    push_exp(0, 32'h4433_2211);
    push_exp(1, 32'h0000_00AB);
    send_prog(1'b1, 1'b0, 0);
    end_prog("partial_last", 2);

    do_reset();
    pbytes.delete();
    for (int i = 0; i < 11; i++) pbytes.push_back(8'($urandom));
    send_prog(1'b1, 1'b1, 2);
    end_prog("gapped", 3);

    do_reset();
    pbytes = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6};
    send_prog(1'b0, 1'b1, 0);
    repeat (2) @(negedge clk);
    check("midload_busy", 32'(busy), 32'd1);
    check("midload_pending", 32'(exp_q.size()), 32'd0);
    do_reset();
    pbytes = '{8'h5E, 8'h6F, 8'h70, 8'h81};
    send_prog(1'b0, 1'b1, 0);
    repeat (2) @(negedge clk);
    $display("reload: word_count=%0d writes=%0d", word_count, writes);
    check("reload_word_count", 32'(word_count), 32'd1);
    check("reload_writes", 32'(writes), 32'd1);
    check("reload_busy", 32'(busy), 32'd1);
    check("reload_core_run", 32'(core_run), 32'd0);
    check("reload_pending", 32'(exp_q.size()), 32'd0);

    do_reset();
    pbytes.delete();
    for (int i = 0; i < 17; i++) pbytes.push_back(8'(i * 7 + 3));
    send_prog(1'b0, 1'b1, 0);
    @(negedge clk);
    $display("overflow: error=%0b core_run=%0b word_count=%0d writes=%0d", error, core_run, word_count, writes);
    check("ovf_error", 32'(error), 32'd1);
    check("ovf_we", 32'(imem_we), 32'd0);
    check("ovf_in_ready", 32'(in_ready), 32'd0);
    check("ovf_word_count", 32'(word_count), 32'd4);
    repeat (3) @(negedge clk);
    check("ovf_core_run", 32'(core_run), 32'd0);
    check("ovf_writes", 32'(writes), 32'd4);
    check("ovf_pending", 32'(exp_q.size()), 32'd0);

    do_reset();
    pbytes = '{8'h5A};
    push_exp(0, 32'h0000_005A);
    send_prog(1'b1, 1'b0, 0);
    end_prog("single_byte", 1);

`ifdef LOADER_CHECKSUM_EN
    do_reset();
    pbytes = '{8'h01, 8'h02, 8'h03, 8'h04};
    push_exp(0, 32'h0403_0201);
    send_prog(1'b1, 1'b0, 0);
    end_prog("csum_good", 1);

    do_reset();
    push_exp(0, 32'h0403_0201);
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    send(8'h03, 1'b0);
    send(8'h04, 1'b1);
    send(8'h00, 1'b0);
    repeat (3) @(negedge clk);
    $display("csum_bad: error=%0b core_run=%0b writes=%0d", error, core_run, writes);
    check("csum_bad_error", 32'(error), 32'd1);
    check("csum_bad_core_run", 32'(core_run), 32'd0);
    check("csum_bad_writes", 32'(writes), 32'd1);
    check("csum_bad_pending", 32'(exp_q.size()), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
